// File: rtl/mw_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mw_pkg
// Purpose  : Shared types and constants for the M->W writeback skid stage.
// Revision : 1.0 - initial release
// ============================================================================
package mw_pkg;

    localparam int MW_DATA_WIDTH = 32;
    localparam int MW_RD_WIDTH   = 5;
    localparam int MW_OPC_WIDTH  = 7;
    localparam int MW_SRC_WIDTH  = 2;

    typedef struct packed {
        logic                     reg_write;
        logic [MW_SRC_WIDTH-1:0]  result_src;
        logic [MW_DATA_WIDTH-1:0] alu_result;
        logic [MW_DATA_WIDTH-1:0] mem_data;
        logic [MW_DATA_WIDTH-1:0] pc_out4;
        logic [MW_RD_WIDTH-1:0]   rd;
        logic [MW_OPC_WIDTH-1:0]  opcode;
    } wb_bundle_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

    localparam logic [MW_SRC_WIDTH-1:0] RES_ALU = 2'd0;
    localparam logic [MW_SRC_WIDTH-1:0] RES_MEM = 2'd1;
    localparam logic [MW_SRC_WIDTH-1:0] RES_PC4 = 2'd2;

endpackage
`default_nettype wire

// File: rtl/wb_result_mux.sv
`default_nettype none
// ============================================================================
// Module   : wb_result_mux
// Purpose  : Writeback result selector, built only with WB_RESULT_MUX_EN.
// Revision : 1.0 - initial release
// ============================================================================
`ifdef WB_RESULT_MUX_EN
module wb_result_mux
    import mw_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SRC_WIDTH  = 2
) (
    input  logic                  i_valid,
    input  logic [SRC_WIDTH-1:0]  i_result_src,
    input  logic [DATA_WIDTH-1:0] i_alu_result,
    input  logic [DATA_WIDTH-1:0] i_mem_data,
    input  logic [DATA_WIDTH-1:0] i_pc_out4,
    output logic [DATA_WIDTH-1:0] o_result
);

    always_comb begin
        o_result = '0;
        if (i_valid) begin
            case (i_result_src)
                SRC_WIDTH'(RES_ALU): o_result = i_alu_result;
                SRC_WIDTH'(RES_MEM): o_result = i_mem_data;
                SRC_WIDTH'(RES_PC4): o_result = i_pc_out4;
                default:             o_result = '0;
            endcase
        end
    end

endmodule
`endif
`default_nettype wire

// File: rtl/mw_skid_stage.sv
`default_nettype none
// ============================================================================
// Module   : mw_skid_stage
// Purpose  : Elastic M->W pipeline register (2-entry skid buffer) with flush;
//            optional W_result selector under WB_RESULT_MUX_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mw_skid_stage
    import mw_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int RD_WIDTH   = 5,
    parameter int OPC_WIDTH  = 7,
    parameter int SRC_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  M_valid,
    output logic                  M_ready,
    input  logic                  M_RegWrite,
    input  logic [SRC_WIDTH-1:0]  M_result_src,
    input  logic [DATA_WIDTH-1:0] M_alu_result,
    input  logic [DATA_WIDTH-1:0] M_mem_data,
    input  logic [DATA_WIDTH-1:0] M_pc_out4,
    input  logic [RD_WIDTH-1:0]   M_rd,
    input  logic [OPC_WIDTH-1:0]  M_opcode,
    output logic                  W_valid,
    input  logic                  W_ready,
    output logic                  W_RegWrite,
    output logic [SRC_WIDTH-1:0]  W_result_src,
    output logic [DATA_WIDTH-1:0] W_alu_result,
    output logic [DATA_WIDTH-1:0] W_mem_data,
    output logic [DATA_WIDTH-1:0] W_pc_out4,
    output logic [RD_WIDTH-1:0]   W_rd,
    output logic [OPC_WIDTH-1:0]  W_opcode
`ifdef WB_RESULT_MUX_EN
    ,
    output logic [DATA_WIDTH-1:0] W_result
`endif
);

    // Widths follow the instance parameters, so the bundle is declared locally
    typedef struct packed {
        logic                  reg_write;
        logic [SRC_WIDTH-1:0]  result_src;
        logic [DATA_WIDTH-1:0] alu_result;
        logic [DATA_WIDTH-1:0] mem_data;
        logic [DATA_WIDTH-1:0] pc_out4;
        logic [RD_WIDTH-1:0]   rd;
        logic [OPC_WIDTH-1:0]  opcode;
    } beat_t;

    skid_state_t r_state;
    beat_t       r_main;
    beat_t       r_skid;
    beat_t       w_in;
    logic        w_main_vld;
    logic        w_in_fire;
    logic        w_out_fire;

    // Entry valid bits are decoded from state, so ready never sees W_ready
    assign w_main_vld = (r_state != EMPTY);
    assign M_ready    = (r_state != TWO);
    assign w_in_fire  = M_valid & M_ready;
    assign w_out_fire = w_main_vld & W_ready;

    assign w_in = '{reg_write:  M_RegWrite,
                    result_src: M_result_src,
                    alu_result: M_alu_result,
                    mem_data:   M_mem_data,
                    pc_out4:    M_pc_out4,
                    rd:         M_rd,
                    opcode:     M_opcode};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else if (flush) begin
            r_state <= EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_in_fire) begin
                        r_main  <= w_in;
                        r_state <= ONE;
                    end
                end
                ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        r_main <= w_in;
                    end else if (w_in_fire) begin
                        r_skid  <= w_in;
                        r_state <= TWO;
                    end else if (w_out_fire) begin
                        r_state <= EMPTY;
                    end
                end
                TWO: begin
                    if (w_out_fire) begin
                        r_main  <= r_skid;
                        r_state <= ONE;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

    assign W_valid      = w_main_vld;
    assign W_RegWrite   = r_main.reg_write & w_main_vld & (r_main.rd != '0);
    assign W_result_src = r_main.result_src;
    assign W_alu_result = r_main.alu_result;
    assign W_mem_data   = r_main.mem_data;
    assign W_pc_out4    = r_main.pc_out4;
    assign W_rd         = r_main.rd;
    assign W_opcode     = r_main.opcode;

`ifdef WB_RESULT_MUX_EN
    wb_result_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .SRC_WIDTH  (SRC_WIDTH)
    ) u_result_mux (
        .i_valid      (w_main_vld),
        .i_result_src (r_main.result_src),
        .i_alu_result (r_main.alu_result),
        .i_mem_data   (r_main.mem_data),
        .i_pc_out4    (r_main.pc_out4),
        .o_result     (W_result)
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_mw_skid_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mw_skid_stage
// Purpose  : Self-checking bench for mw_skid_stage (queue model + directed vectors).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mw_skid_stage;

    typedef struct packed {
        logic        rw;
        logic [1:0]  src;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [6:0]  opc;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst, flush, M_valid, M_ready, M_RegWrite, W_valid, W_ready, W_RegWrite;
    logic [1:0]  M_result_src, W_result_src;
    logic [31:0] M_alu_result, M_mem_data, M_pc_out4;
    logic [31:0] W_alu_result, W_mem_data, W_pc_out4;
    logic [4:0]  M_rd, W_rd;
    logic [6:0]  M_opcode, W_opcode;
`ifdef WB_RESULT_MUX_EN
    logic [31:0] W_result;
`endif

    int checks   = 0;
    int failures = 0;

    beat_t mq[$];
    bit    mzero = 1'b0;
    bit    armed = 1'b0;

    always #5 clk = ~clk;

    mw_skid_stage dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .M_valid      (M_valid),
        .M_ready      (M_ready),
        .M_RegWrite   (M_RegWrite),
        .M_result_src (M_result_src),
        .M_alu_result (M_alu_result),
        .M_mem_data   (M_mem_data),
        .M_pc_out4    (M_pc_out4),
        .M_rd         (M_rd),
        .M_opcode     (M_opcode),
        .W_valid      (W_valid),
        .W_ready      (W_ready),
        .W_RegWrite   (W_RegWrite),
        .W_result_src (W_result_src),
        .W_alu_result (W_alu_result),
        .W_mem_data   (W_mem_data),
        .W_pc_out4    (W_pc_out4),
        .W_rd         (W_rd),
        .W_opcode     (W_opcode)
`ifdef WB_RESULT_MUX_EN
        ,
        .W_result     (W_result)
`endif
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input bit v, input bit rw, input logic [1:0] src,
                       input logic [31:0] alu, input logic [4:0] rd);
        M_valid      = v;
        M_RegWrite   = rw;
        M_result_src = src;
        M_alu_result = alu;
        M_mem_data   = alu ^ 32'h5A5A_0000;
        M_pc_out4    = alu + 32'd4;
        M_rd         = rd;
        M_opcode     = alu[6:0] | 7'h03;
    endtask

    // Model: a FIFO of at most two beats; ready while fewer than two are held
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                mq.delete();
                mzero = 1'b1;
                armed = 1'b1;
            end else if (flush) begin
                mq.delete();
            end else begin
                bit outf;
                bit inf;
                outf = (mq.size() > 0) && W_ready;
                inf  = M_valid && (mq.size() < 2);
                if (outf) void'(mq.pop_front());
                if (inf) begin
                    mq.push_back('{M_RegWrite, M_result_src, M_alu_result, M_mem_data,
                                   M_pc_out4, M_rd, M_opcode});
                    mzero = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (armed) begin
                beat_t h;
                logic [31:0] exp_res;
                chk("cmp_W_valid", W_valid, mq.size() > 0);
                chk("cmp_M_ready", M_ready, mq.size() < 2);
                exp_res = '0;
                if (mq.size() > 0) begin
                    h = mq[0];
                    chk("cmp_bundle", {W_result_src, W_alu_result, W_mem_data, W_pc_out4, W_rd, W_opcode},
                        {h.src, h.alu, h.mem, h.pc, h.rd, h.opc});
                    chk("cmp_W_RegWrite", W_RegWrite, h.rw && (h.rd != 5'd0));
                    case (h.src)
                        2'd0:    exp_res = h.alu;
                        2'd1:    exp_res = h.mem;
                        2'd2:    exp_res = h.pc;
                        default: exp_res = '0;
                    endcase
                end else begin
                    chk("cmp_W_RegWrite_empty", W_RegWrite, 1'b0);
                    if (mzero)
                        chk("cmp_reset_bundle", {W_result_src, W_alu_result, W_mem_data, W_pc_out4, W_rd, W_opcode}, '0);
                end
`ifdef WB_RESULT_MUX_EN
                chk("cmp_W_result", W_result, exp_res);
`endif
            end
        end
    end

    logic [15:0] vpat = 16'b1011_1101_0111_1110;
    logic [15:0] rpat = 16'b0110_0011_1010_1101;
    logic [31:0] mux_exp [4] = '{32'h11, 32'h22, 32'h33, 32'h0};

    initial begin
        rst = 1'b1; flush = 1'b0; W_ready = 1'b1;
        put(0, 0, 2'd0, 32'h0, 5'd0);
        step(); step();
        rst = 1'b0;
        chk("reset_W_valid", W_valid, 1'b0);
        chk("reset_M_ready", M_ready, 1'b1);
        chk("reset_W_alu", W_alu_result, 32'h0);
        chk("reset_W_RegWrite", W_RegWrite, 1'b0);

        // Back-to-back streaming with W_ready high
        put(1, 1, 2'd0, 32'h10, 5'd5); step();
        chk("stream0_alu", W_alu_result, 32'h10);
        chk("stream0_rw", W_RegWrite, 1'b1);
        chk("stream0_ready", M_ready, 1'b1);
        put(1, 1, 2'd0, 32'h20, 5'd5); step();
        chk("stream1_alu", W_alu_result, 32'h20);
        put(1, 1, 2'd0, 32'h30, 5'd5); step();
        chk("stream2_alu", W_alu_result, 32'h30);
        chk("stream2_ready", M_ready, 1'b1);
        M_valid = 1'b0; step();
        chk("stream_drained", W_valid, 1'b0);

        // Backpressure into the skid entry
        W_ready = 1'b0;
        put(1, 1, 2'd0, 32'hA, 5'd7); step();
        put(1, 1, 2'd0, 32'hB, 5'd7); step();
        put(1, 1, 2'd0, 32'hC, 5'd7);
        chk("bp_ready_low", M_ready, 1'b0);
        chk("bp_hold_A", W_alu_result, 32'hA);
        step();
        chk("bp_hold_A2", W_alu_result, 32'hA);
        W_ready = 1'b1;
        chk("bp_drain_A", W_alu_result, 32'hA);
        step();
        chk("bp_drain_B", W_alu_result, 32'hB);
        step();
        chk("bp_drain_C", W_alu_result, 32'hC);
        M_valid = 1'b0; step();
        chk("bp_empty", W_valid, 1'b0);

        // x0 suppression, then flush in TWO with a beat offered
        W_ready = 1'b0;
        put(1, 1, 2'd0, 32'h44, 5'd0); step();
        chk("x0_valid", W_valid, 1'b1);
        chk("x0_rw", W_RegWrite, 1'b0);
        put(1, 1, 2'd0, 32'h55, 5'd9); step();
        chk("two_ready", M_ready, 1'b0);
        put(1, 1, 2'd0, 32'h66, 5'd9); flush = 1'b1; step();
        flush = 1'b0; M_valid = 1'b0;
        chk("flush2_valid", W_valid, 1'b0);
        chk("flush2_ready", M_ready, 1'b1);
        chk("flush2_rw", W_RegWrite, 1'b0);
        W_ready = 1'b1; step(); step();
        chk("flush2_no_ghost", W_valid, 1'b0);

        // Flush in ONE with out_fire and a beat accepted-looking
        put(1, 1, 2'd1, 32'h77, 5'd3); step();
        put(1, 1, 2'd1, 32'h88, 5'd3); flush = 1'b1; step();
        flush = 1'b0; M_valid = 1'b0;
        chk("flush1_valid", W_valid, 1'b0);
        step();
        chk("flush1_no_ghost", W_valid, 1'b0);

        // Reset with both entries occupied
        W_ready = 1'b0;
        put(1, 1, 2'd2, 32'h91, 5'd1); step();
        put(1, 1, 2'd2, 32'h92, 5'd1); step();
        chk("rst_two_ready", M_ready, 1'b0);
        put(1, 1, 2'd2, 32'h93, 5'd1); rst = 1'b1; step();
        chk("rst_W_valid", W_valid, 1'b0);
        chk("rst_M_ready", M_ready, 1'b1);
        chk("rst_bundle", {W_RegWrite, W_result_src, W_alu_result, W_mem_data, W_pc_out4, W_rd, W_opcode}, '0);
        rst = 1'b0; M_valid = 1'b0; W_ready = 1'b1; step();

        // Mixed valid/ready pattern, checked against the model
        for (int i = 0; i < 16; i++) begin
            put(vpat[i], i[0], 2'(i), 32'h100 + 32'(i), 5'(i));
            W_ready = rpat[i];
            step();
        end
        M_valid = 1'b0; W_ready = 1'b1;
        step(); step(); step();

`ifdef WB_RESULT_MUX_EN
        for (int s = 0; s < 4; s++) begin
            put(1, 1, 2'(s), 32'h11, 5'd2);
            M_mem_data = 32'h22;
            M_pc_out4  = 32'h33;
            step();
            chk("mux_sel", W_result, mux_exp[s]);
        end
        M_valid = 1'b0; step();
        chk("mux_empty", W_result, 32'h0);
`endif

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
